// File: rtl/ps2_direction_decoder_if.sv
// ps2_direction_decoder_if: PS/2 pins in, decoded direction and status pulses out.
interface ps2_direction_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [2:0] input_direction;
    logic       key_valid;
    logic       frame_error;

    modport master (
        output ps2_clk, ps2_data,
        input  input_direction, key_valid, frame_error
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output input_direction, key_valid, frame_error
    );
endinterface

// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder: receives PS/2 frames and maps arrow/WASD keys to a 3-bit heading.
module ps2_direction_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input logic               clk,
    input logic               hard_reset,
    ps2_direction_decoder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic [1:0]    clk_sync, data_sync;
    logic          filt, flip, fall, bit_in;
    logic [3:0]    fcnt;
    logic [2:0]    bcnt, bcnt_n;
    logic [7:0]    sh, sh_n, rx_byte;
    logic          par, par_n;
    logic [TW-1:0] timer, timer_n;
    logic          done_n, err_n, byte_done;
    logic          ext, brk;
    logic [2:0]    dir, key_id;
    logic          kv, fe;

    assign bus.input_direction = dir;
    assign bus.key_valid       = kv;
    assign bus.frame_error     = fe;

    // Filtered level only moves after FILTER_LEN consecutive disagreeing samples.
    assign flip = (clk_sync[1] != filt) && (fcnt == 4'(FILTER_LEN - 1));

    always_ff @(posedge clk or negedge hard_reset) begin
        if (!hard_reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt      <= 1'b1;
            fcnt      <= '0;
            fall      <= 1'b0;
            bit_in    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk};
            data_sync <= {data_sync[0], bus.ps2_data};
            fcnt      <= (clk_sync[1] == filt || flip) ? '0 : fcnt + 4'd1;
            filt      <= flip ? clk_sync[1] : filt;
            fall      <= flip && filt;
            bit_in    <= data_sync[1];
        end
    end

    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        sh_n    = sh;
        par_n   = par;
        done_n  = 1'b0;
        err_n   = 1'b0;
        timer_n = (state == IDLE || fall) ? '0 : timer + 1'b1;
        if (state != IDLE && !fall && timer == TW'(TIMEOUT_CYC - 1)) begin
            state_n = IDLE;
            err_n   = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    state_n = bit_in ? IDLE : DATA;
                    err_n   = bit_in;
                    bcnt_n  = '0;
                end
                DATA: begin
                    sh_n    = {bit_in, sh[7:1]};
                    bcnt_n  = bcnt + 3'd1;
                    state_n = (bcnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = bit_in;
                    state_n = STOP;
                end
                default: begin
                    done_n  = bit_in && (^{sh, par});
                    err_n   = !done_n;
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge hard_reset) begin
        if (!hard_reset) begin
            state     <= IDLE;
            bcnt      <= '0;
            sh        <= '0;
            par       <= 1'b0;
            timer     <= '0;
            byte_done <= 1'b0;
            fe        <= 1'b0;
            rx_byte   <= '0;
        end else begin
            state     <= state_n;
            bcnt      <= bcnt_n;
            sh        <= sh_n;
            par       <= par_n;
            timer     <= timer_n;
            byte_done <= done_n;
            fe        <= err_n;
            rx_byte   <= done_n ? sh : rx_byte;
        end
    end

    // Extended codes only match when preceded by E0; plain 75 is keypad 8.
    always_comb begin
        key_id = ext ? ((rx_byte == 8'h75) ? 3'd0 : (rx_byte == 8'h6B) ? 3'd1 :
                        (rx_byte == 8'h72) ? 3'd2 : (rx_byte == 8'h74) ? 3'd3 : 3'd4)
                     : ((rx_byte == 8'h1D) ? 3'd0 : (rx_byte == 8'h1C) ? 3'd1 :
                        (rx_byte == 8'h1B) ? 3'd2 : (rx_byte == 8'h23) ? 3'd3 : 3'd4);
    end

    // The held key is the current direction itself; 4 means nothing held.
    always_ff @(posedge clk or negedge hard_reset) begin
        if (!hard_reset) begin
            ext <= 1'b0;
            brk <= 1'b0;
            dir <= 3'd4;
            kv  <= 1'b0;
        end else begin
            kv <= 1'b0;
            if (fe) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_done) begin
                if (rx_byte == 8'hE0) begin
                    ext <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (key_id != 3'd4 && !brk) begin
                        dir <= key_id;
                        kv  <= 1'b1;
                    end else if (key_id != 3'd4 && key_id == dir) begin
                        dir <= 3'd4;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_direction_decoder.sv
// tb_ps2_direction_decoder: drives PS/2 frames and scoreboards key_valid pulses against expected headings.
module tb_ps2_direction_decoder;
    localparam int HALF = 20;
    localparam int TO   = 1000;

    logic clk = 1'b0;
    logic hard_reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   kv_cnt = 0;
    int   fe_cnt = 0;
    logic [2:0] exp_q[$];

    ps2_direction_decoder_if bus ();

    ps2_direction_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .hard_reset(hard_reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        cycles(HALF);
        bus.ps2_clk = 1'b0;
        cycles(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par = 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(bad_par ? ^b : ~^b);
        send_bit(1'b1);
        cycles(HALF);
    endtask

    always @(negedge clk) begin
        if (hard_reset) begin
            if (bus.key_valid) begin
                kv_cnt++;
                if (exp_q.size() == 0) chk("kv_unexpected", 1, 0);
                else chk("kv_dir", {29'd0, bus.input_direction}, {29'd0, exp_q.pop_front()});
            end
            if (bus.frame_error) fe_cnt++;
        end
    end

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        cycles(3);
        #1;
        chk("rst_dir", bus.input_direction, 4);
        chk("rst_kv", bus.key_valid, 0);
        chk("rst_fe", bus.frame_error, 0);
        hard_reset = 1'b1;
        cycles(100);
        chk("idle_dir", bus.input_direction, 4);
        chk("idle_kv", kv_cnt, 0);
        chk("idle_fe", fe_cnt, 0);

        exp_q.push_back(3'd0);
        send_frame(8'hE0);
        send_frame(8'h75);
        chk("up_q", exp_q.size(), 0);
        chk("up_dir", bus.input_direction, 0);

        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        chk("up_brk_dir", bus.input_direction, 4);
        chk("up_brk_kv", kv_cnt, 1);

        exp_q.push_back(3'd1);
        send_frame(8'h1C);
        chk("a_dir", bus.input_direction, 1);
        exp_q.push_back(3'd3);
        send_frame(8'h23);
        chk("d_dir", bus.input_direction, 3);
        send_frame(8'hF0);
        send_frame(8'h1C);
        chk("a_brk_dir", bus.input_direction, 3);
        chk("over_q", exp_q.size(), 0);

        send_frame(8'h6B, 1'b1);
        chk("par_fe", fe_cnt, 1);
        chk("par_dir", bus.input_direction, 3);
        exp_q.push_back(3'd1);
        send_frame(8'h1C);
        chk("after_par_dir", bus.input_direction, 1);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        cycles(TO + 50);
        chk("to_fe", fe_cnt, 2);
        exp_q.push_back(3'd2);
        send_frame(8'hE0);
        send_frame(8'h72);
        chk("to_next_dir", bus.input_direction, 2);
        chk("to_fe_once", fe_cnt, 2);

        bus.ps2_data = 1'b1;
        bus.ps2_clk  = 1'b0;
        cycles(4);
        bus.ps2_clk  = 1'b1;
        cycles(50);
        chk("glitch_fe", fe_cnt, 2);
        exp_q.push_back(3'd3);
        send_frame(8'h23);
        chk("glitch_dir", bus.input_direction, 3);
        exp_q.push_back(3'd3);
        send_frame(8'h23);
        chk("typematic_q", exp_q.size(), 0);
        chk("typematic_kv", kv_cnt, 7);

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(posedge clk);
        #3 hard_reset = 1'b0;
        #1;
        chk("async_dir", bus.input_direction, 4);
        chk("async_kv", bus.key_valid, 0);
        chk("async_fe", bus.frame_error, 0);
        cycles(5);
        hard_reset = 1'b1;
        cycles(TO + 50);
        chk("async_no_fe", fe_cnt, 2);

        send_frame(8'h75);
        chk("kp8_dir", bus.input_direction, 4);
        chk("kp8_kv", kv_cnt, 7);
        chk("final_q", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
